id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- Decode-to-execute pipeline register of the 5-stage MIPS pipeline. Sits directly downstream of the decode controller and register file.
- Latches the controller's control bundle, the operands, the immediate and the register indices each cycle, and presents them to the EX stage.
- Contains load-use hazard detection: raises a stall to the PC and IF/ID stages and inserts a bubble into EX.
- Handles branch/jump flush and an external whole-pipeline hold.

Parameters:
DATA_W, 32, operand/PC width
RA_W, 5, register-index width
ALUOP_W, 4, ALUOp width (codes 0..11 as issued by controller)

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous active-high reset
hold  in  1  global freeze (memory wait); register contents unchanged
flush  in  1  kill the instruction entering EX (taken branch/jump resolved)
id_alu_op  in  ALUOP_W  controller ALUOp
id_ctrl  in  10  {RegWrite,MemWrite,MemToReg,Branch,Jr,Jump,Jal,RegDst,Signextend,SignextendLoad}
id_rs_data, id_rt_data  in  DATA_W  register-file read data
id_imm  in  16  raw immediate
id_rs, id_rt, id_rd  in  RA_W  instruction register fields
id_pc4  in  DATA_W  PC+4 of decoding instruction
stall  out  1  combinational; freeze PC and IF/ID
ex_valid  out  1  EX slot holds a real instruction
ex_alu_op  out  ALUOP_W  registered ALUOp
ex_ctrl  out  10  registered control bundle, same bit order
ex_rs_data, ex_rt_data  out  DATA_W  registered operands
ex_imm32  out  DATA_W  extended immediate
ex_rs, ex_rt  out  RA_W  registered source indices (for forwarding)
ex_wdst  out  RA_W  resolved write destination
ex_pc4  out  DATA_W  registered PC+4

Behaviour:
- Reset: all registered outputs 0, ex_valid=0. Asynchronous assert; deassert takes effect on the next clk edge. Reset mid-operation discards the in-flight instruction.
- Latency: 1 cycle from id_* to ex_*.
- Update priority at each posedge:
  - hold=1: no change.
  - else flush=1: bubble.
  - else stall=1: bubble.
  - else: load id_* and set ex_valid=1.
- Bubble: ex_valid=0, ex_ctrl=0, ex_alu_op=0, ex_wdst=0. Data fields may take any value; the bench must not check them.
- stall: asserted when all of the following hold:
  - ex_valid=1, ex_ctrl.MemToReg=1, ex_ctrl.RegWrite=1, ex_wdst!=0;
  - ex_wdst==id_rs, or (ex_wdst==id_rt and the decoding instruction reads rt).
  - rt is read when RegDst=0 (R-type/branch) or MemWrite=1 (sw/sh).
- stall is forced to 0 while flush=1, because the decoding instruction is dead.
- stall is independent of hold. The upstream stages OR the two.
- Destination resolution:
  - Jal=1 and Jr=0 -> 31.
  - Jal=1 and Jr=1 (jalr) -> id_rd.
  - RegDst=1 -> id_rt.
  - otherwise -> id_rd.
  - RegWrite=0 -> 0.
- Immediate: zero-extended for ALUOp 3 (andi) and 4 (ori). Sign-extended otherwise.
- Simultaneous flush+stall: flush wins, one bubble, stall=0. Simultaneous hold+flush: hold wins; flush must be re-presented by EX (it remains asserted while held).
- The register never writes $0 semantics itself; the write-back stage respects ex_wdst=0.

Optional Feature:
ID_EX_PERF_CNT_EN
- Defined: adds outputs perf_bubbles and perf_stalls (32-bit, reset 0, wrap at 2^32).
  - perf_bubbles increments on each non-hold edge that inserts a bubble.
  - perf_stalls increments on each non-hold edge with stall=1.
- Undefined: ports and counters absent. Behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - ALUOp code constants (ADD=1 .. BNE=11);
  - control-bundle bit indices (CTRL_REGWRITE=9 .. CTRL_SEXTLOAD=0);
  - CTRL_W=10;
  - REG_RA=31.
- One sub-module, hazard_detect_lu: purely combinational stall logic taking ex_* and id_rs/id_rt/id_ctrl. Instantiated once.

Test Plan:
- Reset mid-stream: rst pulsed high between clk edges while ex_valid=1 -> all outputs 0 immediately, stall=0.
- Normal load: add $3,$1,$2 (ALUOp=1, RegWrite, RegDst=0, rd=3) -> next cycle ex_valid=1, ex_alu_op=1, ex_wdst=3. Then ori imm=16'h8000 -> ex_imm32=32'h00008000. Then addi imm=16'h8000 -> 32'hFFFF8000.
- Load-use: lw $5,0($1) in EX, then decode add $6,$5,$2 -> stall=1 for one cycle, bubble in EX. Next cycle stall=0 and the add enters. A following sw with rt=5 behind lw also stalls. An addi with rt=5 (RegDst=1) does not stall.
- No stall on $0: lw $0 in EX, decoding instruction uses rs=0 -> stall=0.
- Flush and priority:
  - flush=1 with stall condition true -> stall=0, bubble, perf_bubbles+1 (with macro).
  - hold=1 with flush=1 -> ex_* unchanged.
- Destinations: jal -> ex_wdst=31; jalr rd=7 -> 7; sw (RegWrite=0) -> 0; lw rt=9 -> 9.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the ID/EX pipeline register, its hazard
// unit and its interface.
//   - ALUOp codes as issued by the decode controller.
//   - Bit positions inside the 10-bit control bundle.
//   - Write-destination select encoding.
package pipe_pkg;

  localparam int unsigned ALU_ADD = 1;
  localparam int unsigned ALU_SUB = 2;
  localparam int unsigned ALU_AND = 3;
  localparam int unsigned ALU_OR  = 4;
  localparam int unsigned ALU_XOR = 5;
  localparam int unsigned ALU_NOR = 6;
  localparam int unsigned ALU_SLT = 7;
  localparam int unsigned ALU_SLL = 8;
  localparam int unsigned ALU_SRL = 9;
  localparam int unsigned ALU_BEQ = 10;
  localparam int unsigned ALU_BNE = 11;

  localparam int CTRL_W = 10;

  localparam int CTRL_REGWRITE = 9;
  localparam int CTRL_MEMWRITE = 8;
  localparam int CTRL_MEMTOREG = 7;
  localparam int CTRL_BRANCH   = 6;
  localparam int CTRL_JR       = 5;
  localparam int CTRL_JUMP     = 4;
  localparam int CTRL_JAL      = 3;
  localparam int CTRL_REGDST   = 2;
  localparam int CTRL_SEXT     = 1;
  localparam int CTRL_SEXTLOAD = 0;

  // Link register written by jal.
  localparam int unsigned REG_RA = 31;

  typedef enum logic [1:0] {
    WDST_NONE = 2'd0,
    WDST_RA   = 2'd1,
    WDST_RT   = 2'd2,
    WDST_RD   = 2'd3
  } wdst_sel_e;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// id_ex_pipe_reg_if: decode-side inputs and execute-side outputs of the
// ID/EX pipeline register.
//   master: decode stage / pipeline control (drives id_*, hold, flush;
//           receives stall and ex_*)
//   slave : the ID/EX register itself
interface id_ex_pipe_reg_if
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RA_W    = 5,
  parameter int ALUOP_W = 4
);

  logic                hold;
  logic                flush;
  logic [ALUOP_W-1:0]  id_alu_op;
  logic [CTRL_W-1:0]   id_ctrl;
  logic [DATA_W-1:0]   id_rs_data;
  logic [DATA_W-1:0]   id_rt_data;
  logic [15:0]         id_imm;
  logic [RA_W-1:0]     id_rs;
  logic [RA_W-1:0]     id_rt;
  logic [RA_W-1:0]     id_rd;
  logic [DATA_W-1:0]   id_pc4;

  logic                stall;
  logic                ex_valid;
  logic [ALUOP_W-1:0]  ex_alu_op;
  logic [CTRL_W-1:0]   ex_ctrl;
  logic [DATA_W-1:0]   ex_rs_data;
  logic [DATA_W-1:0]   ex_rt_data;
  logic [DATA_W-1:0]   ex_imm32;
  logic [RA_W-1:0]     ex_rs;
  logic [RA_W-1:0]     ex_rt;
  logic [RA_W-1:0]     ex_wdst;
  logic [DATA_W-1:0]   ex_pc4;

  modport master (
    output hold, flush, id_alu_op, id_ctrl, id_rs_data, id_rt_data,
           id_imm, id_rs, id_rt, id_rd, id_pc4,
    input  stall, ex_valid, ex_alu_op, ex_ctrl, ex_rs_data, ex_rt_data,
           ex_imm32, ex_rs, ex_rt, ex_wdst, ex_pc4
  );

  modport slave (
    input  hold, flush, id_alu_op, id_ctrl, id_rs_data, id_rt_data,
           id_imm, id_rs, id_rt, id_rd, id_pc4,
    output stall, ex_valid, ex_alu_op, ex_ctrl, ex_rs_data, ex_rt_data,
           ex_imm32, ex_rs, ex_rt, ex_wdst, ex_pc4
  );

endinterface

// File: rtl/hazard_detect_lu.sv
// hazard_detect_lu: combinational load-use hazard detection.
// Ports:
//   ex_valid_i, ex_regwrite_i, ex_memtoreg_i : state of the instruction in EX
//   ex_wdst_i                                : its resolved destination
//   id_rs_i, id_rt_i                         : source fields being decoded
//   id_regdst_i, id_memwrite_i               : decide whether rt is a source
//   stall_o                                  : load result needed too early
module hazard_detect_lu #(
  parameter int RA_W = 5
) (
  input  logic            ex_valid_i,
  input  logic            ex_regwrite_i,
  input  logic            ex_memtoreg_i,
  input  logic [RA_W-1:0] ex_wdst_i,
  input  logic [RA_W-1:0] id_rs_i,
  input  logic [RA_W-1:0] id_rt_i,
  input  logic            id_regdst_i,
  input  logic            id_memwrite_i,
  output logic            stall_o
);

  logic ex_is_load;
  logic rt_read;

  // A load into $0 produces nothing anyone can consume.
  assign ex_is_load = ex_valid_i & ex_memtoreg_i & ex_regwrite_i & (ex_wdst_i != '0);

  // RegDst=1 means rt is the destination (I-type), unless it is a store,
  // which reads rt as the data to write.
  assign rt_read = ~id_regdst_i | id_memwrite_i;

  assign stall_o = ex_is_load &
                   ((ex_wdst_i == id_rs_i) | (rt_read & (ex_wdst_i == id_rt_i)));

endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: decode-to-execute pipeline register with load-use stall,
// flush and global hold.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   pipe     : id_ex_pipe_reg_if.slave (hold/flush/id_* in, stall/ex_* out)
//   perf_bubbles, perf_stalls : event counters, present only when
//                               ID_EX_PERF_CNT_EN is defined
// Update priority per edge: hold (freeze) > flush (bubble) > stall (bubble)
// > load.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RA_W    = 5,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  id_ex_pipe_reg_if.slave    pipe
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]        perf_bubbles,
  output logic [31:0]        perf_stalls
`endif
);

  logic               ex_valid_q,   ex_valid_d;
  logic [ALUOP_W-1:0] ex_alu_op_q,  ex_alu_op_d;
  logic [CTRL_W-1:0]  ex_ctrl_q,    ex_ctrl_d;
  logic [DATA_W-1:0]  ex_rs_data_q, ex_rs_data_d;
  logic [DATA_W-1:0]  ex_rt_data_q, ex_rt_data_d;
  logic [DATA_W-1:0]  ex_imm32_q,   ex_imm32_d;
  logic [RA_W-1:0]    ex_rs_q,      ex_rs_d;
  logic [RA_W-1:0]    ex_rt_q,      ex_rt_d;
  logic [RA_W-1:0]    ex_wdst_q,    ex_wdst_d;
  logic [DATA_W-1:0]  ex_pc4_q,     ex_pc4_d;

  logic      lu_hit;
  logic      stall;
  logic      bubble;
  logic      zext;
  logic [RA_W-1:0] wdst_id;
  wdst_sel_e wdst_sel;

  hazard_detect_lu #(.RA_W(RA_W)) u_hazard (
    .ex_valid_i    (ex_valid_q),
    .ex_regwrite_i (ex_ctrl_q[CTRL_REGWRITE]),
    .ex_memtoreg_i (ex_ctrl_q[CTRL_MEMTOREG]),
    .ex_wdst_i     (ex_wdst_q),
    .id_rs_i       (pipe.id_rs),
    .id_rt_i       (pipe.id_rt),
    .id_regdst_i   (pipe.id_ctrl[CTRL_REGDST]),
    .id_memwrite_i (pipe.id_ctrl[CTRL_MEMWRITE]),
    .stall_o       (lu_hit)
  );

  // A flushed instruction is dead, so it cannot create a hazard.
  assign stall  = lu_hit & ~pipe.flush;
  assign bubble = pipe.flush | stall;

  always_comb begin
    wdst_sel = WDST_RD;
    if (!pipe.id_ctrl[CTRL_REGWRITE])
      wdst_sel = WDST_NONE;
    else if (pipe.id_ctrl[CTRL_JAL] && !pipe.id_ctrl[CTRL_JR])
      wdst_sel = WDST_RA;
    else if (pipe.id_ctrl[CTRL_JAL])
      wdst_sel = WDST_RD;  // jalr links into rd
    else if (pipe.id_ctrl[CTRL_REGDST])
      wdst_sel = WDST_RT;

    wdst_id = '0;
    case (wdst_sel)
      WDST_NONE: wdst_id = '0;
      WDST_RA:   wdst_id = RA_W'(REG_RA);
      WDST_RT:   wdst_id = pipe.id_rt;
      WDST_RD:   wdst_id = pipe.id_rd;
      default:   wdst_id = '0;
    endcase
  end

  // Logical immediates (andi/ori) are zero-extended.
  assign zext = (pipe.id_alu_op == ALUOP_W'(ALU_AND)) ||
                (pipe.id_alu_op == ALUOP_W'(ALU_OR));

  always_comb begin
    ex_valid_d   = ~bubble;
    ex_alu_op_d  = bubble ? '0 : pipe.id_alu_op;
    ex_ctrl_d    = bubble ? '0 : pipe.id_ctrl;
    ex_wdst_d    = bubble ? '0 : wdst_id;
    // Data fields are don't-care in a bubble; load them unconditionally.
    ex_rs_data_d = pipe.id_rs_data;
    ex_rt_data_d = pipe.id_rt_data;
    ex_rs_d      = pipe.id_rs;
    ex_rt_d      = pipe.id_rt;
    ex_pc4_d     = pipe.id_pc4;
    ex_imm32_d   = zext ? {{(DATA_W-16){1'b0}}, pipe.id_imm}
                        : {{(DATA_W-16){pipe.id_imm[15]}}, pipe.id_imm};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_alu_op_q  <= '0;
      ex_ctrl_q    <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm32_q   <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_wdst_q    <= '0;
      ex_pc4_q     <= '0;
    end else if (!pipe.hold) begin
      ex_valid_q   <= ex_valid_d;
      ex_alu_op_q  <= ex_alu_op_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_imm32_q   <= ex_imm32_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_wdst_q    <= ex_wdst_d;
      ex_pc4_q     <= ex_pc4_d;
    end
  end

  assign pipe.stall      = stall;
  assign pipe.ex_valid   = ex_valid_q;
  assign pipe.ex_alu_op  = ex_alu_op_q;
  assign pipe.ex_ctrl    = ex_ctrl_q;
  assign pipe.ex_rs_data = ex_rs_data_q;
  assign pipe.ex_rt_data = ex_rt_data_q;
  assign pipe.ex_imm32   = ex_imm32_q;
  assign pipe.ex_rs      = ex_rs_q;
  assign pipe.ex_rt      = ex_rt_q;
  assign pipe.ex_wdst    = ex_wdst_q;
  assign pipe.ex_pc4     = ex_pc4_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_bubbles_q, perf_bubbles_d;
  logic [31:0] perf_stalls_q,  perf_stalls_d;

  assign perf_bubbles_d = perf_bubbles_q + 32'(bubble);
  assign perf_stalls_d  = perf_stalls_q + 32'(stall);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_bubbles_q <= '0;
      perf_stalls_q  <= '0;
    end else if (!pipe.hold) begin
      perf_bubbles_q <= perf_bubbles_d;
      perf_stalls_q  <= perf_stalls_d;
    end
  end

  assign perf_bubbles = perf_bubbles_q;
  assign perf_stalls  = perf_stalls_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  localparam logic [9:0] C_ADD  = 10'h200;
  localparam logic [9:0] C_ADDI = 10'h206;
  localparam logic [9:0] C_ORI  = 10'h204;
  localparam logic [9:0] C_LW   = 10'h286;
  localparam logic [9:0] C_SW   = 10'h106;
  localparam logic [9:0] C_JAL  = 10'h218;
  localparam logic [9:0] C_JALR = 10'h228;

  id_ex_pipe_reg_if bus ();

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_bubbles;
  logic [31:0] perf_stalls;
  id_ex_pipe_reg dut (.clk(clk), .rst(rst), .pipe(bus),
                      .perf_bubbles(perf_bubbles), .perf_stalls(perf_stalls));
`else
  id_ex_pipe_reg dut (.clk(clk), .rst(rst), .pipe(bus));
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [9:0] ctrl,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [15:0] imm);
    bus.id_alu_op  = op;
    bus.id_ctrl    = ctrl;
    bus.id_rs      = rs;
    bus.id_rt      = rt;
    bus.id_rd      = rd;
    bus.id_imm     = imm;
    bus.id_rs_data = 32'h1000_0000 | 32'(rs);
    bus.id_rt_data = 32'h2000_0000 | 32'(rt);
    bus.id_pc4     = 32'h0000_4000 | 32'(rd);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.hold  = 1'b0;
    bus.flush = 1'b0;
    drive(4'd0, 10'h000, 5'd0, 5'd0, 5'd0, 16'h0000);
    #12;
    check("rst_valid", 32'(bus.ex_valid), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    rst = 1'b0;

    // add $3,$1,$2
    drive(4'd1, C_ADD, 5'd1, 5'd2, 5'd3, 16'h0020);
    step();
    check("add_valid", 32'(bus.ex_valid), 32'd1);
    check("add_aluop", 32'(bus.ex_alu_op), 32'd1);
    check("add_wdst", 32'(bus.ex_wdst), 32'd3);
    check("add_ctrl", 32'(bus.ex_ctrl), 32'h200);
    check("add_rsdata", bus.ex_rs_data, 32'h1000_0001);
    check("add_rtdata", bus.ex_rt_data, 32'h2000_0002);
    check("add_pc4", bus.ex_pc4, 32'h0000_4003);
    check("add_rs", 32'(bus.ex_rs), 32'd1);
    check("add_rt", 32'(bus.ex_rt), 32'd2);

    // ori $4,$1,0x8000 -> zero-extend
    drive(4'd4, C_ORI, 5'd1, 5'd4, 5'd0, 16'h8000);
    step();
    check("ori_imm", bus.ex_imm32, 32'h0000_8000);
    check("ori_wdst", 32'(bus.ex_wdst), 32'd4);

    // addi $5,$1,0x8000 -> sign-extend
    drive(4'd1, C_ADDI, 5'd1, 5'd5, 5'd0, 16'h8000);
    step();
    check("addi_imm", bus.ex_imm32, 32'hFFFF_8000);
    check("addi_wdst", 32'(bus.ex_wdst), 32'd5);

    // asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    check("mrst_valid", 32'(bus.ex_valid), 32'd0);
    check("mrst_ctrl", 32'(bus.ex_ctrl), 32'd0);
    check("mrst_aluop", 32'(bus.ex_alu_op), 32'd0);
    check("mrst_wdst", 32'(bus.ex_wdst), 32'd0);
    check("mrst_imm", bus.ex_imm32, 32'd0);
    check("mrst_rsdata", bus.ex_rs_data, 32'd0);
    check("mrst_stall", 32'(bus.stall), 32'd0);
    #1 rst = 1'b0;

    // lw $5,0($1) then add $6,$5,$2
    drive(4'd1, C_LW, 5'd1, 5'd5, 5'd0, 16'h0000);
    step();
    check("lw5_wdst", 32'(bus.ex_wdst), 32'd5);
    drive(4'd1, C_ADD, 5'd5, 5'd2, 5'd6, 16'h0000);
    #1;
    check("lu_rs_stall", 32'(bus.stall), 32'd1);
    step();
    check("lu_bub_valid", 32'(bus.ex_valid), 32'd0);
    check("lu_bub_ctrl", 32'(bus.ex_ctrl), 32'd0);
    check("lu_bub_aluop", 32'(bus.ex_alu_op), 32'd0);
    check("lu_bub_wdst", 32'(bus.ex_wdst), 32'd0);
    check("lu_after_stall", 32'(bus.stall), 32'd0);
    step();
    check("lu_add_valid", 32'(bus.ex_valid), 32'd1);
    check("lu_add_wdst", 32'(bus.ex_wdst), 32'd6);

    // lw $5 then sw $5,4($1): store data reads rt
    drive(4'd1, C_LW, 5'd1, 5'd5, 5'd0, 16'h0000);
    step();
    drive(4'd1, C_SW, 5'd1, 5'd5, 5'd0, 16'h0004);
    #1;
    check("lu_sw_stall", 32'(bus.stall), 32'd1);
    step();
    check("lu_sw_bub", 32'(bus.ex_valid), 32'd0);
    step();
    check("sw_valid", 32'(bus.ex_valid), 32'd1);
    check("sw_wdst", 32'(bus.ex_wdst), 32'd0);
    check("sw_ctrl", 32'(bus.ex_ctrl), 32'h106);

    // lw $5 then addi $5,$1,1: rt is a destination, no stall
    drive(4'd1, C_LW, 5'd1, 5'd5, 5'd0, 16'h0000);
    step();
    drive(4'd1, C_ADDI, 5'd1, 5'd5, 5'd0, 16'h0001);
    #1;
    check("addi_nostall", 32'(bus.stall), 32'd0);
    step();
    check("addi_valid", 32'(bus.ex_valid), 32'd1);
    check("addi_imm1", bus.ex_imm32, 32'd1);

    // lw $0 then add $8,$0,$0: no stall on $0
    drive(4'd1, C_LW, 5'd1, 5'd0, 5'd0, 16'h0000);
    step();
    check("lw0_wdst", 32'(bus.ex_wdst), 32'd0);
    drive(4'd1, C_ADD, 5'd0, 5'd0, 5'd8, 16'h0000);
    #1;
    check("r0_nostall", 32'(bus.stall), 32'd0);
    step();
    check("r0_add_valid", 32'(bus.ex_valid), 32'd1);

    // flush together with a stall condition
    drive(4'd1, C_LW, 5'd1, 5'd5, 5'd0, 16'h0000);
    step();
    drive(4'd1, C_ADD, 5'd5, 5'd2, 5'd6, 16'h0000);
    #1;
    check("pre_flush_stall", 32'(bus.stall), 32'd1);
    bus.flush = 1'b1;
    #1;
    check("flush_stall", 32'(bus.stall), 32'd0);
    step();
    bus.flush = 1'b0;
    check("flush_valid", 32'(bus.ex_valid), 32'd0);
    check("flush_ctrl", 32'(bus.ex_ctrl), 32'd0);
    check("flush_wdst", 32'(bus.ex_wdst), 32'd0);
`ifdef ID_EX_PERF_CNT_EN
    check("perf_bub_flush", perf_bubbles, 32'd3);
    check("perf_stl_flush", perf_stalls, 32'd2);
`endif

    // jal -> $31, then hold+flush freezes the register
    drive(4'd0, C_JAL, 5'd0, 5'd0, 5'd0, 16'h0000);
    step();
    check("jal_wdst", 32'(bus.ex_wdst), 32'd31);
    check("jal_valid", 32'(bus.ex_valid), 32'd1);
    drive(4'd0, C_JALR, 5'd9, 5'd0, 5'd7, 16'h0000);
    bus.hold  = 1'b1;
    bus.flush = 1'b1;
    step();
    check("hold_wdst", 32'(bus.ex_wdst), 32'd31);
    check("hold_ctrl", 32'(bus.ex_ctrl), 32'h218);
    check("hold_valid", 32'(bus.ex_valid), 32'd1);
    bus.hold  = 1'b0;
    bus.flush = 1'b0;
    step();
    check("jalr_wdst", 32'(bus.ex_wdst), 32'd7);
    check("jalr_ctrl", 32'(bus.ex_ctrl), 32'h228);

    // lw $9 -> destination rt
    drive(4'd1, C_LW, 5'd1, 5'd9, 5'd0, 16'h0000);
    step();
    check("lw9_wdst", 32'(bus.ex_wdst), 32'd9);

    // stall is independent of hold; held edge changes nothing
    drive(4'd1, C_ADD, 5'd9, 5'd2, 5'd10, 16'h0000);
    bus.hold = 1'b1;
    #1;
    check("hold_stall", 32'(bus.stall), 32'd1);
    step();
    check("hold2_wdst", 32'(bus.ex_wdst), 32'd9);
    check("hold2_valid", 32'(bus.ex_valid), 32'd1);
    bus.hold = 1'b0;
    step();
    check("hold_then_bub", 32'(bus.ex_valid), 32'd0);
    step();
    check("hold_add_wdst", 32'(bus.ex_wdst), 32'd10);
`ifdef ID_EX_PERF_CNT_EN
    check("perf_bub_end", perf_bubbles, 32'd4);
    check("perf_stl_end", perf_stalls, 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
